// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 byte stream to held-key levels for the game controls.
// Tracks E0/F0 prefixes, skips the E1 pause sequence, and abandons stale prefixes after a timeout.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate_cw,
  output logic       raw_rotate_ccw,
  output logic       raw_drop,
  output logic       raw_hold,
  output logic       kb_reset_seen
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};

  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_DOWN  = 2;
  localparam int K_UP    = 3;
  localparam int K_X     = 4;
  localparam int K_Z     = 5;
  localparam int K_SPACE = 6;
  localparam int K_C     = 7;

  state_t          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [2:0]      skip_cnt_q, skip_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      out_q, out_d;
  logic            is_overrun;
  logic            is_prefix;
  logic            timed_out;

  function automatic logic [7:0] key_map(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    if (ext) begin
      case (code)
        8'h6B:   m[K_LEFT]  = 1'b1;
        8'h74:   m[K_RIGHT] = 1'b1;
        8'h72:   m[K_DOWN]  = 1'b1;
        8'h75:   m[K_UP]    = 1'b1;
        default: m = 8'h00;
      endcase
    end else begin
      case (code)
        8'h22:   m[K_X]     = 1'b1;
        8'h1A:   m[K_Z]     = 1'b1;
        8'h29:   m[K_SPACE] = 1'b1;
        8'h21:   m[K_C]     = 1'b1;
        default: m = 8'h00;
      endcase
    end
    return m;
  endfunction

  assign is_overrun = (rx_data == 8'h00) || (rx_data == 8'hFF);
  assign is_prefix  = (rx_data == 8'hE0) || (rx_data == 8'hF0);
  assign timed_out  = (state_q != IDLE) && (tmo_cnt_q >= TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= 8'h00;
      skip_cnt_q <= 3'd0;
      tmo_cnt_q  <= '0;
      out_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      skip_cnt_q <= skip_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_error) begin
      state_d = IDLE;
    end else if (rx_valid) begin
      if (is_overrun) begin
        state_d = IDLE;
      end else if (state_q == SKIP) begin
        state_d = (skip_cnt_q <= 3'd1) ? IDLE : SKIP;
      end else if (rx_data == 8'hE0) begin
        state_d = EXT;
      end else if (rx_data == 8'hF0) begin
        state_d = (state_q == IDLE || state_q == BRK) ? BRK : EXT_BRK;
      end else if (state_q == IDLE && rx_data == 8'hE1) begin
        state_d = SKIP;
      end else begin
        state_d = IDLE;
      end
    end else if (timed_out) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    key_d      = key_q;
    skip_cnt_d = skip_cnt_q;
    out_d      = 8'h00;
    if (rx_valid || rx_error) begin
      tmo_cnt_d = '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    if (rx_error) begin
      key_d      = 8'h00;
      skip_cnt_d = 3'd0;
    end else if (rx_valid) begin
      if (is_overrun) begin
        key_d      = 8'h00;
        skip_cnt_d = 3'd0;
      end else begin
        case (state_q)
          SKIP: skip_cnt_d = skip_cnt_q - 3'd1;
          IDLE: begin
            if (rx_data == 8'hAA) begin
              out_d[7] = 1'b1;
              key_d    = 8'h00;
            end else if (rx_data == 8'hE1) begin
              skip_cnt_d = 3'd7;
            end else if (!is_prefix && rx_data != 8'hFA && rx_data != 8'hFE && rx_data != 8'hEE) begin
              key_d = key_q | key_map(1'b0, rx_data);
            end
          end
          EXT:     if (!is_prefix) key_d = key_q | key_map(1'b1, rx_data);
          BRK:     if (!is_prefix) key_d = key_q & ~key_map(1'b0, rx_data);
          EXT_BRK: if (!is_prefix) key_d = key_q & ~key_map(1'b1, rx_data);
          default: key_d = key_q;
        endcase
      end
    end

    // Outputs are registered from the next key state so levels move one clock after the byte.
    out_d[6:0] = {key_d[K_C], key_d[K_SPACE], key_d[K_Z], key_d[K_UP] | key_d[K_X],
                  key_d[K_DOWN], key_d[K_RIGHT], key_d[K_LEFT]};
  end

  assign raw_left       = out_q[0];
  assign raw_right      = out_q[1];
  assign raw_down       = out_q[2];
  assign raw_rotate_cw  = out_q[3];
  assign raw_rotate_ccw = out_q[4];
  assign raw_drop       = out_q[5];
  assign raw_hold       = out_q[6];
  assign kb_reset_seen  = out_q[7];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboarded random + directed bench for ps2_key_decoder against a sequence-level key model.
module tb_ps2_key_decoder;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_error = 1'b0;
  logic       raw_left, raw_right, raw_down, raw_rotate_cw, raw_rotate_ccw;
  logic       raw_drop, raw_hold, kb_reset_seen;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
    .raw_rotate_cw(raw_rotate_cw), .raw_rotate_ccw(raw_rotate_ccw),
    .raw_drop(raw_drop), .raw_hold(raw_hold), .kb_reset_seen(kb_reset_seen)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Model: every scan code {ext,byte} has a held flag; pending prefix bytes kept as a list.
  bit         held [0:511];
  logic [7:0] seq [$];
  int         skip_left = 0;
  int         last_edge = 0;
  logic [7:0] exp_q [$];
  logic [6:0] levels = 7'd0;

  function automatic bit seq_has(input logic [7:0] b);
    foreach (seq[i]) if (seq[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_out(input bit pulse);
    return {pulse, held[9'h021], held[9'h029], held[9'h01A], held[9'h175] | held[9'h022],
            held[9'h172], held[9'h174], held[9'h16B]};
  endfunction

  task automatic model_clear();
    held = '{default: 1'b0};
    seq.delete();
    skip_left = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit pulse;
    bit ext;
    bit brk;
    bit plain;
    pulse = 1'b0;
    if (b == 8'h00 || b == 8'hFF) begin
      model_clear();
    end else if (skip_left > 0) begin
      skip_left--;
    end else if (seq.size() == 0 && b == 8'hE1) begin
      skip_left = 7;
    end else if (b == 8'hE0) begin
      seq.delete();
      seq.push_back(b);
    end else if (b == 8'hF0) begin
      if (!seq_has(8'hF0)) seq.push_back(b);
    end else begin
      ext   = seq_has(8'hE0);
      brk   = seq_has(8'hF0);
      plain = (seq.size() == 0);
      seq.delete();
      if (plain && b == 8'hAA) begin
        pulse = 1'b1;
        held  = '{default: 1'b0};
      end else if (!(plain && (b == 8'hFA || b == 8'hFE || b == 8'hEE))) begin
        held[{ext, b}] = !brk;
      end
    end
    exp_q.push_back(model_out(pulse));
  endtask

  task automatic send(input logic [7:0] b, input int idle_n);
    int gap;
    repeat (idle_n) @(posedge clk);
    @(posedge clk); #1;
    gap = cyc + 1 - last_edge;
    if (gap > T && (seq.size() != 0 || skip_left != 0)) begin
      seq.delete();
      skip_left = 0;
    end
    model_byte(b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    last_edge = cyc;
  endtask

  task automatic send_err(input int idle_n);
    repeat (idle_n) @(posedge clk);
    @(posedge clk); #1;
    model_clear();
    exp_q.push_back(model_out(1'b0));
    rx_error = 1'b1;
    @(posedge clk); #1;
    rx_error  = 1'b0;
    last_edge = cyc;
  endtask

  task automatic do_reset_check(input string name);
    @(posedge clk); #3;
    model_clear();
    levels = 7'd0;
    rst = 1'b1;
    #1;
    checks++;
    if ({kb_reset_seen, raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw, raw_down, raw_right, raw_left} !== 8'h00) begin
      errors++;
      $display("FAIL %s: outputs %b, required 00000000", name,
               {kb_reset_seen, raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw, raw_down, raw_right, raw_left});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one expected vector per accepted byte/error; otherwise levels must hold and no pulse.
  initial begin
    logic       ev;
    logic [7:0] e;
    logic [7:0] got;
    forever begin
      @(posedge clk);
      ev = (rx_valid || rx_error) && !rst;
      @(negedge clk);
      got = {kb_reset_seen, raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw, raw_down, raw_right, raw_left};
      if (!rst) begin
        checks++;
        if (ev) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: output %b with no expected entry", got);
          end else begin
            e = exp_q.pop_front();
            levels = e[6:0];
            if (got !== e) begin
              errors++;
              $display("FAIL byte_response: got %b, required %b (cycle %0d)", got, e, cyc);
            end
          end
        end else if (got !== {1'b0, levels}) begin
          errors++;
          $display("FAIL idle_hold: got %b, required %b (cycle %0d)", got, {1'b0, levels}, cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tbl [16];
    int r;
    int idle_n;
    logic [7:0] b;
    tbl = '{8'hE0, 8'hF0, 8'hE1, 8'h1A, 8'h22, 8'h29, 8'h21, 8'h6B,
            8'h74, 8'h72, 8'h75, 8'hAA, 8'hFA, 8'h00, 8'h14, 8'hE0};
    model_clear();
    #3;
    checks++;
    if ({kb_reset_seen, raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw, raw_down, raw_right, raw_left} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: outputs nonzero, required 00000000");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Z make/break
    send(8'h1A, 0); send(8'hF0, 1); send(8'h1A, 0);
    // extended left/right, release left only
    send(8'hE0, 0); send(8'h6B, 0); send(8'hE0, 0); send(8'h74, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 0);
    // rotate_cw from X and up
    send(8'h22, 0); send(8'hE0, 0); send(8'h75, 0); send(8'h22, 0);
    send(8'hF0, 0); send(8'h22, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    // pause sequence then space
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 0); send(8'h29, 0);
    // timeout boundary: gap T+1 abandons, gap T does not
    send(8'hE0, 0); send(8'h6B, T - 1);
    send(8'hE0, 0); send(8'h6B, T - 2);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);
    send(8'hE0, 0); send(8'h6B, T + 8);
    // self-test pass and error clear held keys
    send(8'h21, 0); send(8'hAA, 0);
    send(8'h21, 0); send(8'h1A, 0); send_err(0);
    // overrun mid-sequence, typematic repeat, break of unheld key
    send(8'h29, 0); send(8'hE0, 0); send(8'hFF, 0); send(8'h6B, 0);
    send(8'h21, 0); send(8'h21, 0); send(8'hF0, 0); send(8'h1A, 0);
    // reset mid-sequence with keys held
    send(8'h22, 0); send(8'hE0, 0);
    repeat (3) @(posedge clk);
    do_reset_check("reset_midseq");
    send(8'h6B, 0); send(8'h29, 0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      idle_n = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : T + 2 + $urandom_range(0, 3);
      if (r < 3) begin
        send_err(idle_n);
      end else begin
        b = (r < 10) ? 8'($urandom_range(0, 255)) : tbl[$urandom_range(0, 15)];
        send(b, idle_n);
      end
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
